// File: rtl/key_pkg.sv
// Shared types and default timing for the push-button conditioner.
// Defaults assume a 50 MHz clock.
package key_pkg;

    // Debounce FSM state encoding
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        HELD       = 2'd2,
        REL_FILT   = 2'd3
    } key_fsm_e;

    localparam int unsigned DEF_DEBOUNCE_CYC = 1000000;   // 20 ms
    localparam int unsigned DEF_LONG_CYC     = 50000000;  // 1 s
    localparam int unsigned DEF_REPEAT_CYC   = 10000000;  // 200 ms
    localparam int unsigned DEF_CNT_W        = 26;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for an asynchronous single-bit input.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   d          : asynchronous input
//   q          : synchronised output; resets to RST_VAL
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Both stages reset to the idle level of the pin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Push-button conditioner: synchroniser, debounce FSM and hold timer.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   key_n       : raw active-low button pin, asynchronous to clk
//   key_state   : debounced level, 1 = pressed
//   key_press   : one-cycle pulse on accepted press
//   key_release : one-cycle pulse on accepted release
//   key_long    : one-cycle pulse once held LONG_CYC cycles
//   key_repeat  : one-cycle pulse every REPEAT_CYC cycles after key_long
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned LONG_CYC     = DEF_LONG_CYC,
    parameter int unsigned REPEAT_CYC   = DEF_REPEAT_CYC,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_repeat
);

    // Elaboration-time parameter checks
    if (DEBOUNCE_CYC < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYC must be at least 2");
    end
    if (REPEAT_CYC < 2) begin : g_bad_repeat
        $error("REPEAT_CYC must be at least 2");
    end
    if (LONG_CYC <= REPEAT_CYC) begin : g_bad_long
        $error("LONG_CYC must exceed REPEAT_CYC");
    end
    if ((64'(LONG_CYC) - 64'd1) >= (64'd1 << CNT_W)) begin : g_bad_width
        $error("CNT_W too narrow for LONG_CYC-1");
    end

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic key_sync;
    logic active;

    key_fsm_e         state, state_d;
    logic [CNT_W-1:0] filt_cnt, filt_d;
    logic [CNT_W-1:0] hold_cnt, hold_d;
    logic [CNT_W-1:0] rep_cnt, rep_d;
    logic             long_done, long_done_d;
    logic             press_d, release_d, long_d, repeat_d;

    // Timer step shared by HELD and REL_FILT
    logic [CNT_W-1:0] tmr_hold, tmr_rep;
    logic             tmr_done, tmr_long, tmr_repeat;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (key_n),
        .q     (key_sync)
    );

    assign active = ~key_sync;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            filt_cnt    <= '0;
            hold_cnt    <= '0;
            rep_cnt     <= '0;
            long_done   <= 1'b0;
            key_state   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            key_repeat  <= 1'b0;
        end else begin
            state       <= state_d;
            filt_cnt    <= filt_d;
            hold_cnt    <= hold_d;
            rep_cnt     <= rep_d;
            long_done   <= long_done_d;
            key_state   <= (state_d == HELD) || (state_d == REL_FILT);
            key_press   <= press_d;
            key_release <= release_d;
            key_long    <= long_d;
            key_repeat  <= repeat_d;
        end
    end

    // Next-state and pulse logic
    always_comb begin
        state_d     = state;
        filt_d      = filt_cnt;
        hold_d      = hold_cnt;
        rep_d       = rep_cnt;
        long_done_d = long_done;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        repeat_d    = 1'b0;

        // Hold timer saturates at LONG_LAST; long_done keeps key_long one-shot
        tmr_hold   = (hold_cnt == LONG_LAST) ? hold_cnt : hold_cnt + CNT_ONE;
        tmr_done   = long_done;
        tmr_long   = 1'b0;
        tmr_repeat = 1'b0;
        tmr_rep    = rep_cnt;
        if (!long_done) begin
            if (hold_cnt == LONG_LAST) begin
                tmr_long = 1'b1;
                tmr_done = 1'b1;
                tmr_rep  = '0;
            end
        end else if (rep_cnt == REP_LAST) begin
            tmr_repeat = 1'b1;
            tmr_rep    = '0;
        end else begin
            tmr_rep = rep_cnt + CNT_ONE;
        end

        case (state)
            IDLE: begin
                if (active) begin
                    state_d = PRESS_FILT;
                    filt_d  = CNT_ONE;
                end
            end
            PRESS_FILT: begin
                if (!active) begin
                    state_d = IDLE;
                    filt_d  = '0;
                end else if (filt_cnt == DEB_LAST) begin
                    state_d     = HELD;
                    press_d     = 1'b1;
                    filt_d      = '0;
                    hold_d      = '0;
                    rep_d       = '0;
                    long_done_d = 1'b0;
                end else begin
                    filt_d = filt_cnt + CNT_ONE;
                end
            end
            HELD: begin
                hold_d      = tmr_hold;
                rep_d       = tmr_rep;
                long_done_d = tmr_done;
                long_d      = tmr_long;
                repeat_d    = tmr_repeat;
                if (!active) begin
                    state_d = REL_FILT;
                    filt_d  = CNT_ONE;
                end
            end
            REL_FILT: begin
                if (!active && (filt_cnt == DEB_LAST)) begin
                    // Release acceptance wins over any coincident long/repeat
                    state_d     = IDLE;
                    release_d   = 1'b1;
                    filt_d      = '0;
                    hold_d      = '0;
                    rep_d       = '0;
                    long_done_d = 1'b0;
                end else begin
                    hold_d      = tmr_hold;
                    rep_d       = tmr_rep;
                    long_done_d = tmr_done;
                    long_d      = tmr_long;
                    repeat_d    = tmr_repeat;
                    if (active) begin
                        state_d = HELD;
                        filt_d  = '0;
                    end else begin
                        filt_d = filt_cnt + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_key_debounce.sv
module tb_key_debounce;

    logic clk = 1'b0;
    logic rst_n;
    logic key_n;
    logic key_state, key_press, key_release, key_long, key_repeat;

    int compared   = 0;
    int mismatched = 0;

    int cyc = 0;
    int press_cnt, release_cnt, long_cnt, overlap_cnt;
    int press_cyc, release_cyc, long_cyc;
    int rep_q[$];

    always #5 clk = ~clk;

    key_debounce #(
        .DEBOUNCE_CYC (8),
        .LONG_CYC     (40),
        .REPEAT_CYC   (16),
        .CNT_W        (26)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_n       (key_n),
        .key_state   (key_state),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long),
        .key_repeat  (key_repeat)
    );

    task automatic clear_log();
        press_cnt   = 0;
        release_cnt = 0;
        long_cnt    = 0;
        press_cyc   = -1;
        release_cyc = -1;
        long_cyc    = -1;
        rep_q.delete();
    endtask

    // Advance n cycles, sampling 1 ns after each rising edge
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (key_press)   begin press_cnt++;   press_cyc   = cyc; end
            if (key_release) begin release_cnt++; release_cyc = cyc; end
            if (key_long)    begin long_cnt++;    long_cyc    = cyc; end
            if (key_repeat)  rep_q.push_back(cyc);
            if ((int'(key_press) + int'(key_release) + int'(key_long) + int'(key_repeat)) > 1)
                overlap_cnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        key_n = 1'b1;
        overlap_cnt = 0;
        clear_log();
        run(3);
        compared++;
        if ({key_state, key_press, key_release, key_long, key_repeat} !== 5'b0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %b want 00000",
                     {key_state, key_press, key_release, key_long, key_repeat});
        end
        rst_n = 1'b1;
        run(5);
        compared++;
        if ({key_state, press_cnt} !== {1'b0, 32'd0}) begin
            mismatched++;
            $display("FAIL reset_idle: state=%b presses=%0d want 0/0", key_state, press_cnt);
        end
    endtask

    task automatic test_clean_press();
        int e;
        clear_log();
        e = cyc;
        key_n = 1'b0;
        run(30);
        compared++;
        if (press_cnt !== 1 || press_cyc !== e + 10) begin
            mismatched++;
            $display("FAIL clean_press: count=%0d at=%0d want 1 at %0d", press_cnt, press_cyc - e, 10);
        end
        compared++;
        if (key_state !== 1'b1 || long_cnt !== 0 || release_cnt !== 0) begin
            mismatched++;
            $display("FAIL clean_hold: state=%b long=%0d rel=%0d want 1/0/0", key_state, long_cnt, release_cnt);
        end
        e = cyc;
        key_n = 1'b1;
        run(20);
        compared++;
        if (release_cnt !== 1 || release_cyc !== e + 10 || key_state !== 1'b0) begin
            mismatched++;
            $display("FAIL clean_release: count=%0d at=%0d state=%b want 1 at 10 state 0",
                     release_cnt, release_cyc - e, key_state);
        end
    endtask

    task automatic test_press_bounce();
        int e;
        clear_log();
        key_n = 1'b0;
        run(5);
        key_n = 1'b1;
        run(2);
        compared++;
        if (press_cnt !== 0 || key_state !== 1'b0) begin
            mismatched++;
            $display("FAIL press_bounce_quiet: presses=%0d state=%b want 0/0", press_cnt, key_state);
        end
        e = cyc;
        key_n = 1'b0;
        run(20);
        compared++;
        if (press_cnt !== 1 || press_cyc !== e + 10) begin
            mismatched++;
            $display("FAIL press_bounce_accept: count=%0d at=%0d want 1 at 10", press_cnt, press_cyc - e);
        end
        key_n = 1'b1;
        run(20);
        compared++;
        if (release_cnt !== 1 || key_state !== 1'b0) begin
            mismatched++;
            $display("FAIL press_bounce_release: count=%0d state=%b want 1/0", release_cnt, key_state);
        end
    endtask

    task automatic test_release_bounce();
        int e;
        clear_log();
        key_n = 1'b0;
        run(20);
        key_n = 1'b1;
        run(3);
        key_n = 1'b0;
        run(1);
        compared++;
        if (release_cnt !== 0 || key_state !== 1'b1) begin
            mismatched++;
            $display("FAIL release_bounce_quiet: rel=%0d state=%b want 0/1", release_cnt, key_state);
        end
        e = cyc;
        key_n = 1'b1;
        run(20);
        compared++;
        if (release_cnt !== 1 || release_cyc !== e + 10) begin
            mismatched++;
            $display("FAIL release_bounce_accept: count=%0d at=%0d want 1 at 10", release_cnt, release_cyc - e);
        end
        compared++;
        if (key_state !== 1'b0 || long_cnt !== 0 || press_cnt !== 1) begin
            mismatched++;
            $display("FAIL release_bounce_misc: state=%b long=%0d press=%0d want 0/0/1",
                     key_state, long_cnt, press_cnt);
        end
    endtask

    task automatic test_long_press();
        int p;
        clear_log();
        p = cyc + 10;
        key_n = 1'b0;
        run(100);
        key_n = 1'b1;
        run(30);
        compared++;
        if (press_cnt !== 1 || press_cyc !== p) begin
            mismatched++;
            $display("FAIL long_press_edge: count=%0d at=%0d want 1 at %0d", press_cnt, press_cyc, p);
        end
        compared++;
        if (long_cnt !== 1 || long_cyc !== p + 40) begin
            mismatched++;
            $display("FAIL long_pulse: count=%0d at=+%0d want 1 at +40", long_cnt, long_cyc - p);
        end
        compared++;
        if (rep_q.size() !== 3) begin
            mismatched++;
            $display("FAIL repeat_count: got %0d want 3", rep_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                compared++;
                if (rep_q[i] !== p + 56 + 16 * i) begin
                    mismatched++;
                    $display("FAIL repeat_time[%0d]: got +%0d want +%0d", i, rep_q[i] - p, 56 + 16 * i);
                end
            end
        end
        compared++;
        if (release_cnt !== 1 || release_cyc !== p + 100 || key_state !== 1'b0) begin
            mismatched++;
            $display("FAIL long_release: count=%0d at=+%0d state=%b want 1 at +100 state 0",
                     release_cnt, release_cyc - p, key_state);
        end
    endtask

    task automatic test_reset_mid_hold();
        int e;
        clear_log();
        key_n = 1'b0;
        run(20);
        rst_n = 1'b0;
        #1;
        compared++;
        if ({key_state, key_press, key_release, key_long, key_repeat} !== 5'b0) begin
            mismatched++;
            $display("FAIL reset_async: got %b want 00000",
                     {key_state, key_press, key_release, key_long, key_repeat});
        end
        clear_log();
        run(3);
        e = cyc;
        rst_n = 1'b1;
        run(20);
        compared++;
        if (press_cnt !== 1 || press_cyc !== e + 10) begin
            mismatched++;
            $display("FAIL reset_repress: count=%0d at=%0d want 1 at 10", press_cnt, press_cyc - e);
        end
        compared++;
        if (release_cnt !== 0 || key_state !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_no_release: rel=%0d state=%b want 0/1", release_cnt, key_state);
        end
        key_n = 1'b1;
        run(20);
    endtask

    task automatic test_release_long_coincide();
        int p;
        clear_log();
        p = cyc + 10;
        key_n = 1'b0;
        run(40);
        key_n = 1'b1;
        run(30);
        compared++;
        if (release_cnt !== 1 || release_cyc !== p + 40) begin
            mismatched++;
            $display("FAIL coincide_release: count=%0d at=+%0d want 1 at +40", release_cnt, release_cyc - p);
        end
        compared++;
        if (long_cnt !== 0 || rep_q.size() !== 0 || key_state !== 1'b0) begin
            mismatched++;
            $display("FAIL coincide_long: long=%0d rep=%0d state=%b want 0/0/0",
                     long_cnt, rep_q.size(), key_state);
        end
    endtask

    task automatic test_exclusive();
        compared++;
        if (overlap_cnt !== 0) begin
            mismatched++;
            $display("FAIL pulse_exclusive: overlapping cycles=%0d want 0", overlap_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_press_bounce();
        test_release_bounce();
        test_long_press();
        test_reset_mid_hold();
        test_release_long_coincide();
        test_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
